// File: rtl/mdu_unit.sv
// mdu_unit: MIPS multiply/divide unit with HI/LO registers and a fixed-latency busy flag
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0] pend_hi, pend_lo, ua, ub, dv, uq, ur, quo, rem, res_hi, res_lo;
    logic [63:0] ea, eb, prod;
    logic pend_valid, start_op, done, sdiv, an, bn;
    always_comb begin
        start_op = state == IDLE && start && !op[2];
        done = state == RUN && cnt == CW'(1);
        state_n = start_op ? RUN : done ? IDLE : state;
        ea = op[0] ? {32'b0, A} : {{32{A[31]}}, A};
        eb = op[0] ? {32'b0, B} : {{32{B[31]}}, B};
        prod = ea * eb;
        sdiv = ~op[0];
        an = sdiv & A[31];
        bn = sdiv & B[31];
        ua = an ? -A : A;
        ub = bn ? -B : B;
        dv = (ub == 32'd0) ? 32'd1 : ub;
        uq = ua / dv;
        ur = ua % dv;
        quo = (an ^ bn) ? -uq : uq;
        rem = an ? -ur : ur;
        {res_hi, res_lo} = op[1] ? {rem, quo} : prod;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            HI <= '0;
            LO <= '0;
            cnt <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (start_op) begin
                cnt <= op[1] ? DIV_CYCLES[CW-1:0] : MULT_CYCLES[CW-1:0];
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_valid <= !(op[1] && B == 32'd0);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (done && pend_valid) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end else if (start && op == 3'd4) begin
                HI <= A;
            end else if (start && op == 3'd5) begin
                LO <= A;
            end
        end
    end
    assign busy = state == RUN;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and randomized checks of mdu_unit against an arithmetic reference model
module tb_mdu_unit;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy;
    logic [2:0] op = 3'd0;
    logic [31:0] a = '0, b = '0, HI, LO;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    int checks = 0, failures = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Architectural effect of one accepted operation, from the ISA rules.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
        longint sp, sq, sr;
        longint unsigned up;
        n = 0;
        case (o)
            3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); {exp_hi, exp_lo} = sp; n = 5; end
            3'd1: begin up = {32'b0, x}; up = up * {32'b0, y}; {exp_hi, exp_lo} = up; n = 5; end
            3'd2: begin
                n = 10;
                if (y != 0) begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    exp_lo = sq[31:0];
                    exp_hi = sr[31:0];
                end
            end
            3'd3: begin n = 10; if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n, cyc;
        logic [31:0] old_hi, old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(o, x, y, n);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_hold_hi"}, HI, old_hi);
                chk({tag, "_hold_lo"}, LO, old_lo);
            end
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        int n, cyc;
        logic [31:0] x, y;
        logic [2:0] o;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3);
        chk("mult_neg_const_hi", HI, 32'hFFFFFFFF);
        chk("mult_neg_const_lo", LO, 32'hFFFFFFFA);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_const_hi", HI, 32'hFFFFFFFE);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
        chk("div_const_lo", LO, 32'hFFFFFFFD);
        chk("div_const_hi", HI, 32'hFFFFFFFF);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0);
        chk("divu_zero_hi", HI, 32'hFFFFFFFF);
        run_op("div_zero", 3'd2, 32'd9, 32'd0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'h00000000);
        run_op("mthi", 3'd4, 32'h12345678, 32'd0);
        chk("mthi_const", HI, 32'h12345678);
        run_op("nop6", 3'd6, 32'h55555555, 32'd1);
        run_op("nop7", 3'd7, 32'hAAAAAAAA, 32'd2);

        // MULT 2x3 with an MTLO issued on the 2nd busy cycle, which must be ignored.
        model(3'd0, 32'd2, 32'd3, n);
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk); start = 1'b0;
        chk("mtlo_busy1", 32'(busy), 32'd1);
        @(negedge clk); start = 1'b1; op = 3'd5; a = 32'hDEAD;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; @(negedge clk); end
        chk("mtlo_ignored_lo", LO, 32'd6);
        chk("mtlo_ignored_hi", HI, 32'd0);
        chk("mtlo_model_lo", LO, exp_lo);

        // Reset on the 4th busy cycle of a DIV aborts it.
        @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);
        run_op("mult_after_reset", 3'd0, 32'd4, 32'd5);
        chk("mult_after_reset_const", LO, 32'd20);

        // Reset in the same cycle as start wins.
        @(negedge clk); start = 1'b1; reset = 1'b1; op = 3'd4; a = 32'hCAFEF00D;
        @(negedge clk); start = 1'b0; reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        chk("rst_start_hi", HI, 32'd0);
        @(negedge clk); start = 1'b1; reset = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(negedge clk); start = 1'b0; reset = 1'b0;
        chk("rst_start_mult_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFFFFFF;
                2: y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, o), o, x, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the general register file: consumes the two register read ports (rs, rt) as operands and holds the HI/LO result registers.
- mfhi/mflo read HI/LO back into the register-file write-data mux.
- Models multi-cycle latency with a busy flag so the controller can stall dependent instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe, sampled on a rising edge; qualifies op.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 = no-op.
- A  input  32  operand from register read port 1 (rs).
- B  input  32  operand from register read port 2 (rt).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - At the edge: HI=0, LO=0, busy=0, counter=0, pending result cleared.
  - Aborts any in-flight operation; its result is never written.
- States:
  - IDLE (busy=0): the only state in which start is accepted.
  - RUN (busy=1).
- IDLE, start=1, op in {0..3}:
  - At edge T0: A and B are captured, the full 64-bit result is computed into pending_hi/pending_lo, counter is loaded with N (MULT_CYCLES or DIV_CYCLES), busy goes 1, and the state moves to RUN.
- RUN:
  - Counter decrements each edge.
  - At edge T0+N: HI<=pending_hi, LO<=pending_lo, busy<=0, return to IDLE.
  - busy is high for exactly N cycles; new HI/LO are visible in the cycle after busy falls.
- IDLE, start=1, op=4 (MTHI): HI<=A at that edge; busy stays 0; LO unchanged. op=5 (MTLO): LO<=A likewise.
- IDLE, start=1, op in {6,7}: no state change.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO. HI/LO are not corrupted; the controller stalls.
- HI/LO stay stable throughout RUN and hold their pre-operation values until the completion edge.
- Arithmetic:
  - MULT: signed 32x32 -> 64, HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 32x32 -> 64, same split.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
- Boundary cases:
  - Divide by zero (B=0, DIV or DIVU): still busy for DIV_CYCLES; HI and LO are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no exception.
  - Operand changes on A/B during RUN have no effect, since operands are captured at T0.
  - reset asserted in the same cycle as start: reset wins, and the operation is not started.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Then DIVU A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- MTHI A=0x12345678 while idle -> HI=0x12345678 next cycle, busy stays 0.
  - Then start MULT 2x3 and issue MTLO A=0xDEAD on cycle 2 of busy -> MTLO ignored; final LO=6, HI=0.
- Start DIV 100/7, assert reset on cycle 4 of busy -> next cycle busy=0, HI=0, LO=0; no later update occurs.
  - A fresh MULT 4x5 after reset gives LO=20 after 5 cycles.
